// File: rtl/trace_pkg.sv
// Shared types for the commit-trace buffer: record kinds, FSM states and the kind classifier.
package trace_pkg;

  typedef enum logic [2:0] {
    TK_BRN  = 3'd0,
    TK_REG  = 3'd1,
    TK_LD   = 3'd2,
    TK_STU  = 3'd3,
    TK_ST   = 3'd4,
    TK_HALT = 3'd5
  } trace_kind_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_e;

  // First matching rule wins, so HALT masks everything and STU masks LD/REG/ST.
  function automatic trace_kind_e classify(input logic halt, input logic reg_wr,
                                           input logic mem_rd, input logic mem_wr);
    trace_kind_e kind;
    if (halt)                  kind = TK_HALT;
    else if (reg_wr && mem_wr) kind = TK_STU;
    else if (reg_wr && mem_rd) kind = TK_LD;
    else if (reg_wr)           kind = TK_REG;
    else if (mem_wr)           kind = TK_ST;
    else                       kind = TK_BRN;
    return kind;
  endfunction

  function automatic logic kind_has_reg(input trace_kind_e kind);
    return kind inside {TK_REG, TK_LD, TK_STU};
  endfunction

  function automatic logic kind_has_mem_addr(input trace_kind_e kind);
    return kind inside {TK_LD, TK_ST, TK_STU};
  endfunction

  function automatic logic kind_has_mem_data(input trace_kind_e kind);
    return kind inside {TK_ST, TK_STU};
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit input, trace drain port and status outputs of the commit-trace buffer.
// TRACE_CYCLE_STAMP_EN adds tr_cycle.
interface commit_trace_buffer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned CNT_W  = 32
) ();

  logic              cm_valid;
  logic [DATA_W-1:0] cm_pc;
  logic [DATA_W-1:0] cm_inst;
  logic              cm_reg_wr;
  logic [REG_W-1:0]  cm_reg_sel;
  logic [DATA_W-1:0] cm_reg_data;
  logic              cm_mem_rd;
  logic              cm_mem_wr;
  logic [DATA_W-1:0] cm_mem_addr;
  logic [DATA_W-1:0] cm_mem_data;
  logic              cm_halt;

  logic              tr_valid;
  logic              tr_ready;
  logic [2:0]        tr_kind;
  logic [CNT_W-1:0]  tr_inum;
  logic [DATA_W-1:0] tr_pc;
  logic [DATA_W-1:0] tr_inst;
  logic [REG_W-1:0]  tr_reg_sel;
  logic [DATA_W-1:0] tr_reg_data;
  logic [DATA_W-1:0] tr_mem_addr;
  logic [DATA_W-1:0] tr_mem_data;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [CNT_W-1:0]  tr_cycle;
`endif

  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  drop_count;
  logic              overflow;
  logic              done;

  modport master (
    output cm_valid, cm_pc, cm_inst, cm_reg_wr, cm_reg_sel, cm_reg_data,
           cm_mem_rd, cm_mem_wr, cm_mem_addr, cm_mem_data, cm_halt, tr_ready,
    input  tr_valid, tr_kind, tr_inum, tr_pc, tr_inst, tr_reg_sel, tr_reg_data,
           tr_mem_addr, tr_mem_data, cycle_count, drop_count, overflow, done
`ifdef TRACE_CYCLE_STAMP_EN
    , input tr_cycle
`endif
  );

  modport slave (
    input  cm_valid, cm_pc, cm_inst, cm_reg_wr, cm_reg_sel, cm_reg_data,
           cm_mem_rd, cm_mem_wr, cm_mem_addr, cm_mem_data, cm_halt, tr_ready,
    output tr_valid, tr_kind, tr_inum, tr_pc, tr_inst, tr_reg_sel, tr_reg_data,
           tr_mem_addr, tr_mem_data, cycle_count, drop_count, overflow, done
`ifdef TRACE_CYCLE_STAMP_EN
    , output tr_cycle
`endif
  );

endinterface

// File: rtl/trace_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with wrap-bit pointers; the caller never pushes into a
// full FIFO unless it pops in the same cycle.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture: classifies and numbers retiring instructions and queues them for drain.
// Optional TRACE_CYCLE_STAMP_EN stores the cycle count with each record and drives tr_cycle.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 32
) (
  input logic                  clk,
  input logic                  rst,
  commit_trace_buffer_if.slave io_bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    trace_kind_e       kind;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [REG_W-1:0]  reg_sel;
    logic [DATA_W-1:0] reg_data;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CNT_W-1:0]  cycle;
`endif
  } trace_rec_t;

  localparam int unsigned REC_W = $bits(trace_rec_t);

  trace_state_e     r_state;
  logic [CNT_W-1:0] r_inum;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_drops;
  logic             r_overflow;
  logic             r_done;

  trace_kind_e      w_kind;
  trace_rec_t       w_rec;
  trace_rec_t       w_head;
  trace_rec_t       w_out;
  logic [REC_W-1:0] w_head_bits;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic             w_tr_valid;
  logic             w_drain_last;
  logic [AW:0]      w_count;

  assign w_accept   = (r_state == ST_RUN) && io_bus.cm_valid;
  assign w_tr_valid = !w_empty && (r_state != ST_DONE);
  assign w_pop      = w_tr_valid && io_bus.tr_ready;
  // A simultaneous pop frees the slot, so a full FIFO only drops when the head is not taken.
  assign w_push     = w_accept && (!w_full || w_pop);
  assign w_drop     = w_accept && w_full && !w_pop;
  assign w_drain_last = w_empty || ((w_count == (AW+1)'(1)) && w_pop);

  always_comb begin
    w_kind       = classify(io_bus.cm_halt, io_bus.cm_reg_wr, io_bus.cm_mem_rd, io_bus.cm_mem_wr);
    w_rec        = '0;
    w_rec.kind   = w_kind;
    w_rec.inum   = r_inum;
    w_rec.pc     = io_bus.cm_pc;
    w_rec.inst   = io_bus.cm_inst;
    if (kind_has_reg(w_kind)) begin
      w_rec.reg_sel  = io_bus.cm_reg_sel;
      w_rec.reg_data = io_bus.cm_reg_data;
    end
    if (kind_has_mem_addr(w_kind)) w_rec.mem_addr = io_bus.cm_mem_addr;
    if (kind_has_mem_data(w_kind)) w_rec.mem_data = io_bus.cm_mem_data;
`ifdef TRACE_CYCLE_STAMP_EN
    // Stamp the count as it stands after this cycle, so a HALT carries the frozen final value.
    w_rec.cycle  = r_cycle + CNT_W'(1);
`endif
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_rec),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head = trace_rec_t'(w_head_bits);
  assign w_out  = w_tr_valid ? w_head : trace_rec_t'('0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_inum     <= '0;
      r_cycle    <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_cycle <= r_cycle + CNT_W'(1);
          if (w_accept) begin
            r_inum <= r_inum + CNT_W'(1);
            if (io_bus.cm_halt) r_state <= ST_DRAIN;
          end
          if (w_drop) begin
            if (r_drops != '1) r_drops <= r_drops + CNT_W'(1);
            r_overflow <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_drain_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: ;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign io_bus.tr_valid    = w_tr_valid;
  assign io_bus.tr_kind     = w_out.kind;
  assign io_bus.tr_inum     = w_out.inum;
  assign io_bus.tr_pc       = w_out.pc;
  assign io_bus.tr_inst     = w_out.inst;
  assign io_bus.tr_reg_sel  = w_out.reg_sel;
  assign io_bus.tr_reg_data = w_out.reg_data;
  assign io_bus.tr_mem_addr = w_out.mem_addr;
  assign io_bus.tr_mem_data = w_out.mem_data;
`ifdef TRACE_CYCLE_STAMP_EN
  assign io_bus.tr_cycle    = w_out.cycle;
`endif
  assign io_bus.cycle_count = r_cycle;
  assign io_bus.drop_count  = r_drops;
  assign io_bus.overflow    = r_overflow;
  assign io_bus.done        = r_done;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized bench for commit_trace_buffer against a queue-based model of the trace rules.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_trace_buffer_if #(.DATA_W(16), .REG_W(3), .CNT_W(32)) bus ();

  commit_trace_buffer #(
    .DATA_W (16),
    .REG_W  (3),
    .DEPTH  (DEPTH),
    .CNT_W  (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    bit        valid;
    bit [15:0] pc, inst;
    bit        reg_wr;
    bit [2:0]  sel;
    bit [15:0] rdata;
    bit        mem_rd, mem_wr;
    bit [15:0] maddr, mdata;
    bit        halt;
  } commit_t;

  typedef struct {
    int unsigned kind;
    int unsigned inum;
    bit [15:0]   pc, inst;
    bit [2:0]    sel;
    bit [15:0]   rdata, maddr, mdata;
    int unsigned cyc;
  } rec_t;

  rec_t        q[$];
  int unsigned m_inum, m_cycle, m_drops;
  bit          m_ovf, m_halted, m_done;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic commit_t idle();
    commit_t c;
    c = '{default: 0};
    return c;
  endfunction

  function automatic commit_t mk(bit [15:0] pc, bit [15:0] inst, bit reg_wr, bit [2:0] sel,
                                 bit [15:0] rdata, bit mem_rd, bit mem_wr, bit [15:0] maddr,
                                 bit [15:0] mdata, bit halt);
    commit_t c;
    c = '{valid: 1'b1, pc: pc, inst: inst, reg_wr: reg_wr, sel: sel, rdata: rdata,
          mem_rd: mem_rd, mem_wr: mem_wr, maddr: maddr, mdata: mdata, halt: halt};
    return c;
  endfunction

  function automatic commit_t rnd_commit(bit allow_halt);
    return mk(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              allow_halt && ($urandom_range(0, 79) == 0));
  endfunction

  function automatic rec_t make_rec(commit_t c);
    rec_t r;
    int unsigned k;
    if (c.halt)                     k = 5;
    else if (c.reg_wr && c.mem_wr)  k = 3;
    else if (c.reg_wr && c.mem_rd)  k = 2;
    else if (c.reg_wr)              k = 1;
    else if (c.mem_wr)              k = 4;
    else                            k = 0;
    r.kind  = k;
    r.inum  = m_inum;
    r.pc    = c.pc;
    r.inst  = c.inst;
    r.sel   = (k inside {1, 2, 3}) ? c.sel   : 3'd0;
    r.rdata = (k inside {1, 2, 3}) ? c.rdata : 16'd0;
    r.maddr = (k inside {2, 3, 4}) ? c.maddr : 16'd0;
    r.mdata = (k inside {3, 4})    ? c.mdata : 16'd0;
    r.cyc   = m_cycle + 1;
    return r;
  endfunction

  task automatic model_step(input commit_t c, input bit ready, input bit r);
    bit ev;
    if (r) begin
      q.delete();
      m_inum = 0; m_cycle = 0; m_drops = 0; m_ovf = 0; m_halted = 0; m_done = 0;
      return;
    end
    ev = (q.size() > 0) && !m_done;
    if (ev && ready) q.delete(0);
    if (!m_halted) begin
      if (c.valid) begin
        if (q.size() < DEPTH) q.push_back(make_rec(c));
        else begin
          if (m_drops != 32'hFFFF_FFFF) m_drops++;
          m_ovf = 1;
        end
        m_inum++;
        if (c.halt) m_halted = 1;
      end
      m_cycle++;
    end else if (!m_done && q.size() == 0) begin
      m_done = 1;
    end
  endtask

  task automatic compare_outputs();
    bit ev;
    ev = (q.size() > 0) && !m_done;
    check_eq("tr_valid", bus.tr_valid, ev);
    if (ev) begin
      check_eq("tr_kind",     bus.tr_kind,     q[0].kind);
      check_eq("tr_inum",     bus.tr_inum,     q[0].inum);
      check_eq("tr_pc",       bus.tr_pc,       q[0].pc);
      check_eq("tr_inst",     bus.tr_inst,     q[0].inst);
      check_eq("tr_reg_sel",  bus.tr_reg_sel,  q[0].sel);
      check_eq("tr_reg_data", bus.tr_reg_data, q[0].rdata);
      check_eq("tr_mem_addr", bus.tr_mem_addr, q[0].maddr);
      check_eq("tr_mem_data", bus.tr_mem_data, q[0].mdata);
`ifdef TRACE_CYCLE_STAMP_EN
      check_eq("tr_cycle",    bus.tr_cycle,    q[0].cyc);
`endif
    end
    check_eq("cycle_count", bus.cycle_count, m_cycle);
    check_eq("drop_count",  bus.drop_count,  m_drops);
    check_eq("overflow",    bus.overflow,    m_ovf);
    check_eq("done",        bus.done,        m_done);
  endtask

  task automatic drive(input commit_t c, input bit ready, input bit r);
    rst              = r;
    bus.cm_valid     = c.valid;
    bus.cm_pc        = c.pc;
    bus.cm_inst      = c.inst;
    bus.cm_reg_wr    = c.reg_wr;
    bus.cm_reg_sel   = c.sel;
    bus.cm_reg_data  = c.rdata;
    bus.cm_mem_rd    = c.mem_rd;
    bus.cm_mem_wr    = c.mem_wr;
    bus.cm_mem_addr  = c.maddr;
    bus.cm_mem_data  = c.mdata;
    bus.cm_halt      = c.halt;
    bus.tr_ready     = ready;
  endtask

  // One clock: check current outputs, advance the model, apply inputs, land on the next negedge.
  task automatic step(input commit_t c, input bit ready, input bit r);
    compare_outputs();
    model_step(c, ready, r);
    drive(c, ready, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned exp_kind [4];
    int unsigned ready_pct;
    exp_kind = '{1, 2, 4, 0};

    drive(idle(), 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_step(idle(), 1'b0, 1'b1);

    check_eq("rst_tr_valid",    bus.tr_valid,    0);
    check_eq("rst_tr_kind",     bus.tr_kind,     0);
    check_eq("rst_tr_inum",     bus.tr_inum,     0);
    check_eq("rst_tr_pc",       bus.tr_pc,       0);
    check_eq("rst_tr_reg_data", bus.tr_reg_data, 0);
    check_eq("rst_cycle_count", bus.cycle_count, 0);
    check_eq("rst_drop_count",  bus.drop_count,  0);
    check_eq("rst_overflow",    bus.overflow,    0);
    check_eq("rst_done",        bus.done,        0);

    // REG, LD, ST, BRN back to back with the consumer always ready.
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: step(mk(16'h0000, 16'h1301, 1, 3'd3, 16'h1234, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        1: step(mk(16'h0002, 16'h2140, 1, 3'd1, 16'h00AA, 1, 0, 16'h0040, 0, 0), 1'b1, 1'b0);
        2: step(mk(16'h0004, 16'h3042, 0, 0, 0, 0, 1, 16'h0042, 16'h5555, 0), 1'b1, 1'b0);
        default: step(mk(16'h0006, 16'h4000, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
      endcase
      check_eq("seq_kind", bus.tr_kind, exp_kind[i]);
      check_eq("seq_inum", bus.tr_inum, i);
    end
    step(mk(16'h0008, 16'h5244, 1, 3'd2, 16'h0044, 0, 1, 16'h0044, 16'h7777, 0), 1'b1, 1'b0);
    check_eq("stu_kind",     bus.tr_kind,     3);
    check_eq("stu_reg_data", bus.tr_reg_data, 16'h0044);
    check_eq("stu_mem_addr", bus.tr_mem_addr, 16'h0044);
    check_eq("stu_mem_data", bus.tr_mem_data, 16'h7777);
    step(idle(), 1'b1, 1'b0);

    // Overflow: 18 commits into a stalled FIFO of 16.
    step(idle(), 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) step(rnd_commit(0), 1'b0, 1'b0);
    check_eq("ovf_drop_count", bus.drop_count, 2);
    check_eq("ovf_overflow",   bus.overflow,   1);
    check_eq("ovf_head_inum",  bus.tr_inum,    0);
    step(rnd_commit(0), 1'b1, 1'b0);
    check_eq("full_pushpop_drops", bus.drop_count, 2);
    check_eq("full_pushpop_head",  bus.tr_inum,    1);
    step(rnd_commit(0), 1'b0, 1'b0);
    check_eq("full_still_full", bus.drop_count, 3);
    for (int i = 0; i < 18; i++) step(idle(), 1'b1, 1'b0);
    check_eq("drained_valid", bus.tr_valid, 0);

    // HALT at inum 7 with records queued, further commits ignored while draining.
    step(idle(), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(rnd_commit(0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(rnd_commit(0), 1'b0, 1'b0);
    step(mk(16'h000E, 16'hF000, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(rnd_commit(0), 1'b0, 1'b0);
    check_eq("halt_cycle_frozen", bus.cycle_count, 8);
    for (int i = 0; i < 8; i++) step(rnd_commit(0), 1'b1, 1'b0);
    check_eq("halt_done",     bus.done,        1);
    check_eq("halt_tr_valid", bus.tr_valid,    0);
    check_eq("halt_cycles",   bus.cycle_count, 8);

    // Reset while draining with records still queued.
    step(idle(), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(rnd_commit(0), 1'b0, 1'b0);
    step(mk(16'h0010, 16'hF000, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b0);
    step(rnd_commit(0), 1'b0, 1'b0);
    step(rnd_commit(0), 1'b1, 1'b1);
    check_eq("rstdrain_valid",  bus.tr_valid,    0);
    check_eq("rstdrain_done",   bus.done,        0);
    check_eq("rstdrain_cycles", bus.cycle_count, 0);
    step(rnd_commit(0), 1'b0, 1'b0);
    check_eq("rstdrain_inum",   bus.tr_inum,     0);
    check_eq("rstdrain_valid2", bus.tr_valid,    1);

    // Random traffic with phases of differing consumer throughput.
    ready_pct = 60;
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit rdy;
      commit_t c;
      if (i % 200 == 0) ready_pct = ($urandom_range(0, 2) == 0) ? 20 : (($urandom_range(0, 1) == 0) ? 60 : 95);
      r   = ($urandom_range(0, 599) == 0) || (m_done && $urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 99) < ready_pct);
      c   = ($urandom_range(0, 99) < 75) ? rnd_commit(1) : idle();
      step(c, rdy, r);
    end
    compare_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
